logistic_scheduler: RTL and testbench

Time-multiplexes one pipelined logistic-map datapath across LANES independent trajectories.
- Each lane is seeded from a common base value plus its lane index.
- Each lane is iterated a programmable number of times, in strict round-robin order.
- The final values are published as a snapshot for the pixel/colour logic.
- The scheduler replaces one full-width multiplier pair per trajectory with a single shared pair, sequenced by a small FSM with a start/done handshake.

---
 rtl/logistic_scheduler_if.sv | 38 +++
 rtl/logistic_scheduler.sv | 178 +++++++++++++++++
 tb/tb_logistic_scheduler.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/logistic_scheduler_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : logistic_scheduler_if
//  Purpose  : Control/result bundle between a logistic-map iteration client
//             and the shared-datapath scheduler.
//  Signals  : start       - one-cycle job request (client -> scheduler)
//             times       - iterations per lane, CW bits
//             mu          - map parameter, unsigned Q2.16
//             dzero       - base seed, unsigned Q1.16
//             busy        - job in progress (scheduler -> client)
//             done        - one-cycle snapshot-updated pulse
//             result_flat - LANES x 17-bit snapshot, lane i at [17*i +: 17]
//  Revision : 1.0 - initial release
// ============================================================================
interface logistic_scheduler_if #(
  parameter int LANES = 4,
  parameter int CW    = 16
);
  logic                 start;
  logic [CW-1:0]        times;
  logic [17:0]          mu;
  logic [16:0]          dzero;
  logic                 busy;
  logic                 done;
  logic [LANES*17-1:0]  result_flat;

  modport master (
    output start, times, mu, dzero,
    input  busy, done, result_flat
  );

  modport slave (
    input  start, times, mu, dzero,
    output busy, done, result_flat
  );
endinterface
`default_nettype wire

// File: rtl/logistic_scheduler.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : logistic_scheduler
//  Purpose  : Time-multiplexes one two-stage logistic-map datapath
//             x' = mu * x * (1 - x) across LANES trajectories. Lanes are
//             seeded with dzero + lane index, iterated 'times' times each in
//             strict round-robin order, then published as one snapshot.
//  Ports    : CLK        - clock
//             RST        - synchronous reset, active-high
//             bus.start  - job request, sampled only in IDLE
//             bus.times  - iterations per lane (latched at start)
//             bus.mu     - Q2.16 map parameter (latched at start)
//             bus.dzero  - Q1.16 base seed (used only at start)
//             bus.busy   - high from start acceptance until done
//             bus.done   - one-cycle pulse when result_flat is updated
//             bus.result_flat - snapshot, lane i at [17*i +: 17]
//  Notes    : LANES must be 2..16; with a single lane the writeback of an
//             issue would land after that lane's next issue.
//  Revision : 1.0 - initial release
// ============================================================================
module logistic_scheduler #(
  parameter int LANES = 4,
  parameter int CW    = 16
) (
  input  wire logic           CLK,
  input  wire logic           RST,
  logistic_scheduler_if.slave bus
);

  localparam int LW = $clog2(LANES);

  localparam logic [1:0] c_IDLE    = 2'd0;
  localparam logic [1:0] c_RUN     = 2'd1;
  localparam logic [1:0] c_DRAIN   = 2'd2;
  localparam logic [1:0] c_PUBLISH = 2'd3;

  localparam logic [LW-1:0] c_LAST_LANE = LW'(LANES - 1);
  localparam logic [16:0]   c_ONE       = 17'h10000;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [1:0]          r_state;
  logic [17:0]         r_mu;
  logic [CW-1:0]       r_times;
  logic [CW-1:0]       r_round;     // completed round-robin passes
  logic [LW-1:0]       r_ptr;       // lane issued at the next RUN edge
  logic [16:0]         r_lane [LANES];

  // Stage-1 register between issue and writeback
  logic                r_s1_valid;
  logic [LW-1:0]       r_s1_id;
  logic [16:0]         r_s1_t;

  logic                r_busy;
  logic                r_done;
  logic [LANES*17-1:0] r_result;

  // --------------------------------------------------------------------------
  // Issue stage: t = x*(1-x) in Q1.16. Values above 1.0 would make (1-x)
  // negative, so they are clamped to a zero term instead.
  // --------------------------------------------------------------------------
  logic [16:0] w_x;
  logic [16:0] w_omx;
  logic [33:0] w_t_prod;
  logic [16:0] w_t;

  assign w_x      = r_lane[r_ptr];
  assign w_omx    = c_ONE - w_x;
  assign w_t_prod = {17'd0, w_x} * {17'd0, w_omx};
  assign w_t      = (w_x > c_ONE) ? 17'd0 : 17'(w_t_prod >> 16);

  // --------------------------------------------------------------------------
  // Writeback stage: x' = mu * t, kept modulo 2^17 like the lane registers.
  // --------------------------------------------------------------------------
  logic [34:0] w_wb_prod;
  logic [16:0] w_wb;

  assign w_wb_prod = {17'd0, r_mu} * {18'd0, r_s1_t};
  assign w_wb      = 17'(w_wb_prod >> 16);

  // --------------------------------------------------------------------------
  // Control decodes
  // --------------------------------------------------------------------------
  logic w_last_issue;
  logic w_accept;

  assign w_last_issue = (r_ptr == c_LAST_LANE) && (r_round == r_times - CW'(1));
  // The cycle in which done is high is the tail of PUBLISH: a start landing
  // there is refused so the client cannot chain a job off the done pulse.
  assign w_accept     = (r_state == c_IDLE) && bus.start && !r_done;

  // --------------------------------------------------------------------------
  // Sequencer and datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= c_IDLE;
      r_mu       <= '0;
      r_times    <= '0;
      r_round    <= '0;
      r_ptr      <= '0;
      r_s1_valid <= 1'b0;
      r_s1_id    <= '0;
      r_s1_t     <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_result   <= '0;
      for (int i = 0; i < LANES; i++) begin
        r_lane[i] <= '0;
      end
    end else begin
      r_done     <= 1'b0;
      r_s1_valid <= 1'b0;

      // A lane's writeback always lands before its next issue because at
      // least one other lane is issued in between.
      if (r_s1_valid) begin
        r_lane[r_s1_id] <= w_wb;
      end

      case (r_state)
        c_IDLE: begin
          if (w_accept) begin
            r_mu    <= bus.mu;
            r_times <= bus.times;
            r_ptr   <= '0;
            r_round <= '0;
            r_busy  <= 1'b1;
            for (int i = 0; i < LANES; i++) begin
              r_lane[i] <= bus.dzero + 17'(i);
            end
            r_state <= (bus.times == '0) ? c_PUBLISH : c_RUN;
          end
        end

        c_RUN: begin
          r_s1_valid <= 1'b1;
          r_s1_id    <= r_ptr;
          r_s1_t     <= w_t;
          if (r_ptr == c_LAST_LANE) begin
            r_ptr   <= '0;
            r_round <= r_round + CW'(1);
          end else begin
            r_ptr   <= r_ptr + LW'(1);
          end
          if (w_last_issue) begin
            r_state <= c_DRAIN;
          end
        end

        c_DRAIN: begin
          r_state <= c_PUBLISH;
        end

        c_PUBLISH: begin
          for (int i = 0; i < LANES; i++) begin
            r_result[17*i +: 17] <= r_lane[i];
          end
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= c_IDLE;
        end

        default: begin
          r_state <= c_IDLE;
        end
      endcase
    end
  end

  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.result_flat = r_result;

endmodule
`default_nettype wire

// File: tb/tb_logistic_scheduler.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_logistic_scheduler
//  Purpose  : Self-checking bench for logistic_scheduler. Jobs push their
//             expected snapshot and done cycle into a scoreboard; a monitor
//             pops and compares on every done pulse.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_logistic_scheduler;

  localparam int LANES = 4;
  localparam int CW    = 16;
  localparam int RW    = LANES * 17;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  logistic_scheduler_if #(.LANES(LANES), .CW(CW)) bus ();

  logistic_scheduler #(.LANES(LANES), .CW(CW)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus.slave)
  );

  typedef struct {
    logic [RW-1:0] snap;
    int            cyc;
  } exp_t;

  exp_t          sb[$];
  int            cyc         = 0;
  int            vectors     = 0;
  int            miscompares = 0;
  logic [RW-1:0] last_snap   = '0;

  always @(posedge CLK) cyc <= cyc + 1;

  // Reference: each lane iterated independently with plain arithmetic.
  function automatic logic [RW-1:0] model(input longint dz, input longint m, input longint t);
    logic [RW-1:0] s;
    longint x, tt;
    s = '0;
    for (int i = 0; i < LANES; i++) begin
      x = (dz + i) % 131072;
      for (longint n = 0; n < t; n++) begin
        tt = (x > 65536) ? 0 : (x * (65536 - x)) / 65536;
        x  = ((m * tt) / 65536) % 131072;
      end
      s[17*i +: 17] = 17'(x);
    end
    return s;
  endfunction

  function automatic logic [16:0] lane_of(input logic [RW-1:0] v, input int i);
    return v[17*i +: 17];
  endfunction

  task automatic check(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // --------------------------------------------------------------------------
  // Monitor: scoreboard on done, snapshot stability otherwise.
  // --------------------------------------------------------------------------
  always @(negedge CLK) begin
    exp_t e;
    if (RST) begin
      last_snap = bus.result_flat;
    end else if (bus.done) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL spurious_done: got done=1 at cycle %0d expected no pending job", cyc);
      end else begin
        e = sb.pop_front();
        vectors++;
        if (bus.result_flat !== e.snap) begin
          miscompares++;
          $display("FAIL snapshot: got %h expected %h", bus.result_flat, e.snap);
        end
        vectors++;
        if (cyc != e.cyc) begin
          miscompares++;
          $display("FAIL done_cycle: got %0d expected %0d", cyc, e.cyc);
        end
      end
      last_snap = bus.result_flat;
    end else begin
      vectors++;
      if (bus.result_flat !== last_snap) begin
        miscompares++;
        $display("FAIL snapshot_stable: got %h expected %h", bus.result_flat, last_snap);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Driver helpers
  // --------------------------------------------------------------------------
  task automatic start_job(input logic [16:0] dz, input logic [17:0] m, input logic [CW-1:0] t);
    exp_t e;
    @(negedge CLK);
    bus.dzero = dz;
    bus.mu    = m;
    bus.times = t;
    bus.start = 1'b1;
    e.snap = model(longint'(dz), longint'(m), longint'(t));
    // start is sampled at the next posedge, i.e. edge cyc+1
    e.cyc  = (t == '0) ? (cyc + 2) : (cyc + 1 + LANES * int'(t) + 2);
    sb.push_back(e);
    @(negedge CLK);
    bus.start = 1'b0;
    bus.dzero = 17'($urandom);
    bus.mu    = 18'($urandom);
    bus.times = CW'($urandom);
  endtask

  task automatic wait_done(input bit chk_busy);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 1000) begin
      @(negedge CLK);
      n++;
      if (chk_busy && !bus.done && sb.size() != 0)
        check("busy_during_run", RW'(bus.busy), RW'(1));
    end
    if (sb.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL done_timeout: got no done after %0d cycles expected a done pulse", n);
      sb.delete();
    end
  endtask

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  initial begin
    int n;
    bus.start = 1'b0;
    bus.times = '0;
    bus.mu    = '0;
    bus.dzero = '0;
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    repeat (10) @(negedge CLK);
    check("reset_busy",   RW'(bus.busy), RW'(0));
    check("reset_done",   RW'(bus.done), RW'(0));
    check("reset_result", bus.result_flat, '0);

    // Reference trajectory with a known lane-0 result
    start_job(17'h08240, 18'h38000, 16'd1);
    wait_done(1'b1);
    check("lane0_known", RW'(lane_of(bus.result_flat, 0)), RW'(17'h0DFEB));

    // Zero iterations: snapshot equals the seeds, including wraparound
    start_job(17'h1FFFF, 18'h2ABCD, 16'd0);
    wait_done(1'b0);
    check("t0_lane0", RW'(lane_of(bus.result_flat, 0)), RW'(17'h1FFFF));
    check("t0_lane1", RW'(lane_of(bus.result_flat, 1)), RW'(17'h00000));
    check("t0_lane2", RW'(lane_of(bus.result_flat, 2)), RW'(17'h00001));
    check("t0_lane3", RW'(lane_of(bus.result_flat, 3)), RW'(17'h00002));

    // Boundary seeds
    start_job(17'h10000, 18'h3FFFF, 16'd3);
    wait_done(1'b1);
    check("seed_one", RW'(lane_of(bus.result_flat, 0)), RW'(17'h00000));
    start_job(17'h08000, 18'h3FFFF, 16'd1);
    wait_done(1'b1);
    check("seed_half", RW'(lane_of(bus.result_flat, 0)), RW'(17'h0FFFF));
    start_job(17'h18000, 18'h2AAAA, 16'd2);
    wait_done(1'b1);
    check("seed_clamp", RW'(lane_of(bus.result_flat, 0)), RW'(17'h00000));

    // start in the same cycle as done is refused
    start_job(17'h05555, 18'h3C000, 16'd2);
    n = 0;
    while (!bus.done && n < 100) begin
      @(negedge CLK);
      n++;
    end
    bus.start = 1'b1;
    bus.mu    = 18'h3FFFF;
    bus.times = 16'd1;
    @(negedge CLK);
    bus.start = 1'b0;
    check("start_on_done_busy", RW'(bus.busy), RW'(0));
    check("start_on_done_done", RW'(bus.done), RW'(0));
    wait_done(1'b0);
    repeat (3) @(negedge CLK);
    check("start_on_done_idle", RW'(bus.busy), RW'(0));

    // Second start mid-run is ignored
    start_job(17'h06000, 18'h30000, 16'd3);
    repeat (4) @(negedge CLK);
    bus.start = 1'b1;
    bus.mu    = 18'h01234;
    bus.times = 16'd9;
    bus.dzero = 17'h1ABCD;
    @(negedge CLK);
    bus.start = 1'b0;
    wait_done(1'b1);

    // Randomised jobs
    for (int j = 0; j < 20; j++) begin
      start_job(17'($urandom), 18'($urandom), CW'($urandom_range(0, 6)));
      wait_done(1'b1);
    end

    // Reset mid-run aborts without a done pulse
    start_job(17'h0A5A5, 18'h3A000, 16'd100);
    repeat (30) @(negedge CLK);
    RST = 1'b1;
    sb.delete();
    @(negedge CLK);
    check("abort_busy",   RW'(bus.busy), RW'(0));
    check("abort_done",   RW'(bus.done), RW'(0));
    check("abort_result", bus.result_flat, '0);
    @(negedge CLK);
    RST = 1'b0;
    start_job(17'h0C0DE, 18'h39000, 16'd100);
    wait_done(1'b1);

    repeat (5) @(negedge CLK);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no end of test expected completion within 100000 cycles");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
